// File: rtl/mem_wb_multi.sv
// =============================================================================
// Module   : mem_wb_multi
// Brief    : Multi-lane MEM/WB pipeline register with in-bundle exception
//            precision and a retired-instruction counter.
// Revision : 1.0
// =============================================================================
`default_nettype none

module mem_wb_multi #(
  parameter int LANES      = 2,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CP0_ADDR_W = 8,
  parameter int CNT_W      = 32,
  localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [LANES-1:0]               mem_valid,
  input  logic [LANES*32-1:0]            mem_pc,
  input  logic [LANES-1:0]               mem_reg_we,
  input  logic [LANES*REG_ADDR_W-1:0]    mem_reg_waddr,
  input  logic [LANES*DATA_W-1:0]        mem_reg_wdata,
  input  logic [LANES-1:0]               mem_hilo_we,
  input  logic [LANES*2*DATA_W-1:0]      mem_hilo,
  input  logic [LANES-1:0]               mem_cp0_we,
  input  logic [LANES*CP0_ADDR_W-1:0]    mem_cp0_waddr,
  input  logic [LANES*DATA_W-1:0]        mem_cp0_wdata,
  input  logic                           except_valid,
  input  logic [LW-1:0]                  except_lane,
  input  logic                           except_cp0_we,
  input  logic [CP0_ADDR_W-1:0]          except_cp0_waddr,
  input  logic [DATA_W-1:0]              except_cp0_wdata,
  input  logic                           stall_mem,
  input  logic                           stall_wb,
  input  logic                           flush,
  output logic [LANES-1:0]               wb_valid,
  output logic [LANES*32-1:0]            wb_pc,
  output logic [LANES-1:0]               wb_reg_we,
  output logic [LANES*REG_ADDR_W-1:0]    wb_reg_waddr,
  output logic [LANES*DATA_W-1:0]        wb_reg_wdata,
  output logic [LANES-1:0]               wb_hilo_we,
  output logic [LANES*2*DATA_W-1:0]      wb_hilo,
  output logic [LANES-1:0]               wb_cp0_we,
  output logic [LANES*CP0_ADDR_W-1:0]    wb_cp0_waddr,
  output logic [LANES*DATA_W-1:0]        wb_cp0_wdata,
  output logic [CNT_W-1:0]               wb_retire_cnt
);

  localparam int c_HW = 2 * DATA_W;

  logic [LW-1:0]                w_exc_lane;
  logic [LANES-1:0]             w_valid, w_reg_we, w_hilo_we, w_cp0_we;
  logic [LANES*32-1:0]          w_pc;
  logic [LANES*REG_ADDR_W-1:0]  w_reg_waddr;
  logic [LANES*DATA_W-1:0]      w_reg_wdata, w_cp0_wdata;
  logic [LANES*c_HW-1:0]        w_hilo;
  logic [LANES*CP0_ADDR_W-1:0]  w_cp0_waddr;
  logic [CNT_W-1:0]             w_retire;

  logic [LANES-1:0]             r_valid, r_reg_we, r_hilo_we, r_cp0_we;
  logic [LANES*32-1:0]          r_pc;
  logic [LANES*REG_ADDR_W-1:0]  r_reg_waddr;
  logic [LANES*DATA_W-1:0]      r_reg_wdata, r_cp0_wdata;
  logic [LANES*c_HW-1:0]        r_hilo;
  logic [LANES*CP0_ADDR_W-1:0]  r_cp0_waddr;
  logic [CNT_W-1:0]             r_retire_cnt;

  // Out-of-range fault indices are clamped onto the youngest lane.
  assign w_exc_lane = (int'(except_lane) > LANES - 1) ? LW'(LANES - 1) : except_lane;

  always_comb begin
    w_valid     = '0;
    w_pc        = '0;
    w_reg_we    = '0;
    w_reg_waddr = '0;
    w_reg_wdata = '0;
    w_hilo_we   = '0;
    w_hilo      = '0;
    w_cp0_we    = '0;
    w_cp0_waddr = '0;
    w_cp0_wdata = '0;
    w_retire    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mem_valid[i] && !(except_valid && i > int'(w_exc_lane))) begin
        w_valid[i]                               = 1'b1;
        w_pc[i*32 +: 32]                         = mem_pc[i*32 +: 32];
        w_reg_we[i]                              = mem_reg_we[i];
        w_reg_waddr[i*REG_ADDR_W +: REG_ADDR_W]  = mem_reg_waddr[i*REG_ADDR_W +: REG_ADDR_W];
        w_reg_wdata[i*DATA_W +: DATA_W]          = mem_reg_wdata[i*DATA_W +: DATA_W];
        w_hilo_we[i]                             = mem_hilo_we[i];
        w_hilo[i*c_HW +: c_HW]                   = mem_hilo[i*c_HW +: c_HW];
        w_cp0_we[i]                              = mem_cp0_we[i];
        w_cp0_waddr[i*CP0_ADDR_W +: CP0_ADDR_W]  = mem_cp0_waddr[i*CP0_ADDR_W +: CP0_ADDR_W];
        w_cp0_wdata[i*DATA_W +: DATA_W]          = mem_cp0_wdata[i*DATA_W +: DATA_W];
        if (except_valid && i == int'(w_exc_lane)) begin
          w_reg_we[i]  = 1'b0;
          w_hilo_we[i] = 1'b0;
        end else begin
          w_retire = w_retire + CNT_W'(1);
        end
      end
      // The exception-unit CP0 write lands even on an empty faulting slot.
      if (except_valid && except_cp0_we && i == int'(w_exc_lane)) begin
        w_cp0_we[i]                              = 1'b1;
        w_cp0_waddr[i*CP0_ADDR_W +: CP0_ADDR_W]  = except_cp0_waddr;
        w_cp0_wdata[i*DATA_W +: DATA_W]          = except_cp0_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= '0;
      r_pc         <= '0;
      r_reg_we     <= '0;
      r_reg_waddr  <= '0;
      r_reg_wdata  <= '0;
      r_hilo_we    <= '0;
      r_hilo       <= '0;
      r_cp0_we     <= '0;
      r_cp0_waddr  <= '0;
      r_cp0_wdata  <= '0;
      r_retire_cnt <= '0;
    end else if (flush || (stall_mem && !stall_wb)) begin
      r_valid      <= '0;
      r_pc         <= '0;
      r_reg_we     <= '0;
      r_reg_waddr  <= '0;
      r_reg_wdata  <= '0;
      r_hilo_we    <= '0;
      r_hilo       <= '0;
      r_cp0_we     <= '0;
      r_cp0_waddr  <= '0;
      r_cp0_wdata  <= '0;
    end else if (!stall_mem) begin
      r_valid      <= w_valid;
      r_pc         <= w_pc;
      r_reg_we     <= w_reg_we;
      r_reg_waddr  <= w_reg_waddr;
      r_reg_wdata  <= w_reg_wdata;
      r_hilo_we    <= w_hilo_we;
      r_hilo       <= w_hilo;
      r_cp0_we     <= w_cp0_we;
      r_cp0_waddr  <= w_cp0_waddr;
      r_cp0_wdata  <= w_cp0_wdata;
      r_retire_cnt <= r_retire_cnt + w_retire;
    end
  end

  assign wb_valid      = r_valid;
  assign wb_pc         = r_pc;
  assign wb_reg_we     = r_reg_we;
  assign wb_reg_waddr  = r_reg_waddr;
  assign wb_reg_wdata  = r_reg_wdata;
  assign wb_hilo_we    = r_hilo_we;
  assign wb_hilo       = r_hilo;
  assign wb_cp0_we     = r_cp0_we;
  assign wb_cp0_waddr  = r_cp0_waddr;
  assign wb_cp0_wdata  = r_cp0_wdata;
  assign wb_retire_cnt = r_retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_multi.sv
// =============================================================================
// Module   : tb_mem_wb_multi
// Brief    : Directed self-checking bench for mem_wb_multi (LANES=2, CNT_W=4).
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_mem_wb_multi;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   mem_valid, mem_reg_we, mem_hilo_we, mem_cp0_we;
  logic [63:0]  mem_pc, mem_reg_wdata, mem_cp0_wdata;
  logic [9:0]   mem_reg_waddr;
  logic [127:0] mem_hilo;
  logic [15:0]  mem_cp0_waddr;
  logic         except_valid, except_cp0_we;
  logic [0:0]   except_lane;
  logic [7:0]   except_cp0_waddr;
  logic [31:0]  except_cp0_wdata;
  logic         stall_mem, stall_wb, flush;
  logic [1:0]   wb_valid, wb_reg_we, wb_hilo_we, wb_cp0_we;
  logic [63:0]  wb_pc, wb_reg_wdata, wb_cp0_wdata;
  logic [9:0]   wb_reg_waddr;
  logic [127:0] wb_hilo;
  logic [15:0]  wb_cp0_waddr;
  logic [3:0]   wb_retire_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  mem_wb_multi #(.LANES(2), .DATA_W(32), .REG_ADDR_W(5), .CP0_ADDR_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_reg_we(mem_reg_we), .mem_reg_waddr(mem_reg_waddr), .mem_reg_wdata(mem_reg_wdata),
    .mem_hilo_we(mem_hilo_we), .mem_hilo(mem_hilo),
    .mem_cp0_we(mem_cp0_we), .mem_cp0_waddr(mem_cp0_waddr), .mem_cp0_wdata(mem_cp0_wdata),
    .except_valid(except_valid), .except_lane(except_lane), .except_cp0_we(except_cp0_we),
    .except_cp0_waddr(except_cp0_waddr), .except_cp0_wdata(except_cp0_wdata),
    .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_reg_we(wb_reg_we), .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata),
    .wb_hilo_we(wb_hilo_we), .wb_hilo(wb_hilo),
    .wb_cp0_we(wb_cp0_we), .wb_cp0_waddr(wb_cp0_waddr), .wb_cp0_wdata(wb_cp0_wdata),
    .wb_retire_cnt(wb_retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_valid = '0; mem_pc = '0; mem_reg_we = '0; mem_reg_waddr = '0; mem_reg_wdata = '0;
    mem_hilo_we = '0; mem_hilo = '0; mem_cp0_we = '0; mem_cp0_waddr = '0; mem_cp0_wdata = '0;
    except_valid = 1'b0; except_lane = '0; except_cp0_we = 1'b0;
    except_cp0_waddr = '0; except_cp0_wdata = '0;
    stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
  endtask

  task automatic set_reg(input int i, input logic [31:0] pc, input logic we,
                         input logic [4:0] addr, input logic [31:0] data);
    mem_valid[i] = 1'b1;
    mem_pc[i*32 +: 32] = pc;
    mem_reg_we[i] = we;
    mem_reg_waddr[i*5 +: 5] = addr;
    mem_reg_wdata[i*32 +: 32] = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 128'(wb_valid), 128'h0);
    check({tag, "_pc"}, 128'(wb_pc), 128'h0);
    check({tag, "_wdata"}, 128'(wb_reg_wdata), 128'h0);
    check({tag, "_cp0we"}, 128'(wb_cp0_we), 128'h0);
    check({tag, "_hilo"}, wb_hilo, 128'h0);
  endtask

  initial begin
    clear_inputs();
    #2 rst_n = 1'b0;
    #1;
    check_empty("reset");
    check("reset_cnt", 128'(wb_retire_cnt), 128'h0);
    @(negedge clk) rst_n = 1'b1;

    // Plain advance of two full lanes.
    set_reg(0, 32'h100, 1'b1, 5'd3, 32'hAAAA_0001);
    set_reg(1, 32'h104, 1'b1, 5'd4, 32'h5);
    mem_hilo_we = 2'b01; mem_hilo[63:0] = 64'h1111_2222_3333_4444;
    tick();
    check("adv_valid", 128'(wb_valid), 128'h3);
    check("adv_we", 128'(wb_reg_we), 128'h3);
    check("adv_waddr", 128'(wb_reg_waddr), 128'h083);
    check("adv_wdata", 128'(wb_reg_wdata), 128'h0000_0005_AAAA_0001);
    check("adv_pc", 128'(wb_pc), 128'h0000_0104_0000_0100);
    check("adv_hilo_we", 128'(wb_hilo_we), 128'h1);
    check("adv_hilo", wb_hilo, 128'h1111_2222_3333_4444);
    check("adv_cnt", 128'(wb_retire_cnt), 128'd2);

    // Fault in lane 0 with injected CP0 write.
    mem_cp0_we = 2'b01; mem_cp0_waddr[7:0] = 8'h60; mem_cp0_wdata[31:0] = 32'h77;
    except_valid = 1'b1; except_lane = 1'b0; except_cp0_we = 1'b1;
    except_cp0_waddr = 8'h68; except_cp0_wdata = 32'h10;
    tick();
    check("ex0_valid", 128'(wb_valid), 128'h1);
    check("ex0_reg_we", 128'(wb_reg_we), 128'h0);
    check("ex0_hilo_we", 128'(wb_hilo_we), 128'h0);
    check("ex0_waddr", 128'(wb_reg_waddr), 128'h003);
    check("ex0_wdata", 128'(wb_reg_wdata), 128'h0000_0000_AAAA_0001);
    check("ex0_hilo", wb_hilo, 128'h1111_2222_3333_4444);
    check("ex0_cp0_we", 128'(wb_cp0_we), 128'h1);
    check("ex0_cp0_addr", 128'(wb_cp0_waddr), 128'h0068);
    check("ex0_cp0_data", 128'(wb_cp0_wdata), 128'h0000_0000_0000_0010);
    check("ex0_pc", 128'(wb_pc), 128'h0000_0000_0000_0100);
    check("ex0_cnt", 128'(wb_retire_cnt), 128'd2);

    // Fault in lane 1, no injected write: lane 1 keeps its own CP0 request.
    mem_hilo_we = 2'b11;
    mem_cp0_we = 2'b10; mem_cp0_waddr = 16'h6100; mem_cp0_wdata = 64'h0000_0099_0000_0000;
    except_lane = 1'b1; except_cp0_we = 1'b0;
    tick();
    check("ex1_valid", 128'(wb_valid), 128'h3);
    check("ex1_reg_we", 128'(wb_reg_we), 128'h1);
    check("ex1_hilo_we", 128'(wb_hilo_we), 128'h1);
    check("ex1_waddr", 128'(wb_reg_waddr), 128'h083);
    check("ex1_cp0_we", 128'(wb_cp0_we), 128'h2);
    check("ex1_cp0_addr", 128'(wb_cp0_waddr), 128'h6100);
    check("ex1_cp0_data", 128'(wb_cp0_wdata), 128'h0000_0099_0000_0000);
    check("ex1_cnt", 128'(wb_retire_cnt), 128'd3);

    // Injection into an empty faulting lane.
    mem_valid = 2'b01; mem_cp0_we = 2'b00; mem_hilo_we = 2'b00;
    except_cp0_we = 1'b1; except_cp0_waddr = 8'h68; except_cp0_wdata = 32'h10;
    tick();
    check("inj_valid", 128'(wb_valid), 128'h1);
    check("inj_cp0_we", 128'(wb_cp0_we), 128'h2);
    check("inj_cp0_addr", 128'(wb_cp0_waddr), 128'h6800);
    check("inj_cp0_data", 128'(wb_cp0_wdata), 128'h0000_0010_0000_0000);
    check("inj_wdata", 128'(wb_reg_wdata), 128'h0000_0000_AAAA_0001);
    check("inj_cnt", 128'(wb_retire_cnt), 128'd4);

    // Stall matrix.
    clear_inputs();
    set_reg(0, 32'h200, 1'b1, 5'd7, 32'h1234);
    set_reg(1, 32'h204, 1'b1, 5'd8, 32'h5678);
    tick();
    check("d_cnt", 128'(wb_retire_cnt), 128'd6);
    set_reg(0, 32'h300, 1'b1, 5'd9, 32'hDEAD);
    stall_mem = 1'b1; stall_wb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_valid", 128'(wb_valid), 128'h3);
      check("hold_wdata", 128'(wb_reg_wdata), 128'h0000_5678_0000_1234);
      check("hold_pc", 128'(wb_pc), 128'h0000_0204_0000_0200);
      check("hold_cnt", 128'(wb_retire_cnt), 128'd6);
    end
    stall_wb = 1'b0;
    tick();
    check_empty("bubble");
    check("bubble_cnt", 128'(wb_retire_cnt), 128'd6);

    stall_mem = 1'b0;
    tick();
    check("re_adv_wdata", 128'(wb_reg_wdata), 128'h0000_5678_0000_DEAD);
    check("re_adv_cnt", 128'(wb_retire_cnt), 128'd8);
    flush = 1'b1;
    tick();
    check_empty("flush");
    check("flush_cnt", 128'(wb_retire_cnt), 128'd8);
    flush = 1'b0;
    tick();
    check("adv2_cnt", 128'(wb_retire_cnt), 128'd10);
    flush = 1'b1; stall_mem = 1'b1; stall_wb = 1'b1;
    tick();
    check_empty("flush_over_hold");
    check("flush_over_hold_cnt", 128'(wb_retire_cnt), 128'd10);
    flush = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
    tick();
    check("adv3_valid", 128'(wb_valid), 128'h3);

    // Reset asserted during a hold clears at once.
    stall_mem = 1'b1; stall_wb = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check_empty("midrst");
    check("midrst_cnt", 128'(wb_retire_cnt), 128'h0);
    @(negedge clk) rst_n = 1'b1;
    stall_mem = 1'b0; stall_wb = 1'b0;

    // Counter wrap at 4 bits: 7x(+2) -> 14, +1 -> 15, +2 -> 1.
    for (int k = 0; k < 7; k++) tick();
    check("wrap_14", 128'(wb_retire_cnt), 128'd14);
    mem_valid = 2'b10;
    tick();
    check("wrap_15", 128'(wb_retire_cnt), 128'd15);
    mem_valid = 2'b11;
    tick();
    check("wrap_1", 128'(wb_retire_cnt), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
